// File: rtl/mem_bank_arbiter_if.sv
// rtl/mem_bank_arbiter_if.sv - PE request bus and SRAM bank bus bundle for mem_bank_arbiter
//
// Purpose: groups the per-PE data request/response signals and the single-port
// bank signals so the arbiter and its neighbours connect through one port.
// Signals (widths in terms of NUM_PE / MEM_AW):
//   i_data_addr   NUM_PE*32  byte address per port, port p at [p*32+:32]
//   i_data_wdata  NUM_PE*32  write data per port
//   i_data_we     NUM_PE     1 = write, 0 = read
//   i_data_req    NUM_PE     request valid
//   i_data_be     NUM_PE*4   byte enables per port
//   o_data_gnt    NUM_PE     accept / advance per port
//   o_data_rvalid NUM_PE     one-cycle response pulse per port
//   o_data_rdata  NUM_PE*32  read data per port
//   o_mem_en/we/be/addr/wdata  bank access, i_mem_rdata bank read data
// Modports: master = PE/bank side, slave = arbiter.
interface mem_bank_arbiter_if #(
  parameter int NUM_PE = 3,
  parameter int MEM_AW = 14
);
  logic [NUM_PE*32-1:0] i_data_addr;
  logic [NUM_PE*32-1:0] i_data_wdata;
  logic [NUM_PE-1:0]    i_data_we;
  logic [NUM_PE-1:0]    i_data_req;
  logic [NUM_PE*4-1:0]  i_data_be;
  logic [NUM_PE-1:0]    o_data_gnt;
  logic [NUM_PE-1:0]    o_data_rvalid;
  logic [NUM_PE*32-1:0] o_data_rdata;
  logic                 o_mem_en;
  logic                 o_mem_we;
  logic [3:0]           o_mem_be;
  logic [MEM_AW-1:0]    o_mem_addr;
  logic [31:0]          o_mem_wdata;
  logic [31:0]          i_mem_rdata;

  modport master (
    output i_data_addr, i_data_wdata, i_data_we, i_data_req, i_data_be, i_mem_rdata,
    input  o_data_gnt, o_data_rvalid, o_data_rdata,
    input  o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
  );

  modport slave (
    input  i_data_addr, i_data_wdata, i_data_we, i_data_req, i_data_be, i_mem_rdata,
    output o_data_gnt, o_data_rvalid, o_data_rdata,
    output o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_bank_arbiter.sv
// rtl/mem_bank_arbiter.sv - round-robin arbiter of per-PE requests onto one single-port SRAM bank
//
// Purpose: picks one requesting PE per cycle, drives the bank combinationally
// with its request, grants idle ports so the insertion stage can always load,
// and returns a one-cycle rvalid pulse (plus read data for reads) next cycle.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      mem_bank_arbiter_if.slave (PE request/response bus + bank bus)
// Configuration macro: MEM_ARB_FIXED_PRIO_EN
//   defined   -> no rotating pointer, lowest-indexed requester always wins
//   undefined -> round-robin starting from the pointer
module mem_bank_arbiter #(
  parameter int NUM_PE = 3,
  parameter int MEM_AW = 14
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mem_bank_arbiter_if.slave bus
);

  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  // Response tag: captured at grant time, consumed one cycle later.
  logic          r_rsp_v;
  logic [PW-1:0] r_rsp_port;
  logic          r_rsp_we;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_found;
  int            w_idx;
`endif

  logic                 w_any_req;
  logic [PW-1:0]        w_winner;
  logic                 w_drive;
  logic [NUM_PE-1:0]    w_gnt;
  logic [NUM_PE-1:0]    w_rvalid;
  logic [NUM_PE*32-1:0] w_rdata;
  logic                 w_mem_we;
  logic [3:0]           w_mem_be;
  logic [MEM_AW-1:0]    w_mem_addr;
  logic [31:0]          w_mem_wdata;
  logic [31:0]          w_sel_addr;

  // Winner selection.
  always_comb begin
    w_any_req = |bus.i_data_req;
    w_winner  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest requesting index is the last write.
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (bus.i_data_req[i]) w_winner = PW'(i);
    end
`else
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_PE) w_idx = w_idx - NUM_PE;
      if (!w_found && bus.i_data_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(w_idx);
      end
    end
    w_next_ptr = (w_winner == PW'(NUM_PE - 1)) ? '0 : PW'(w_winner + 1'b1);
`endif
  end

  // Bank drive and grants. Reset gating keeps every output quiet while
  // i_rst_n is low, independent of what the PEs present.
  always_comb begin
    w_drive     = i_rst_n & w_any_req;
    w_sel_addr  = bus.i_data_addr[int'(w_winner)*32 +: 32];
    w_mem_we    = w_drive & bus.i_data_we[w_winner];
    w_mem_be    = w_drive ? bus.i_data_be[int'(w_winner)*4 +: 4] : 4'b0;
    w_mem_addr  = w_drive ? w_sel_addr[MEM_AW+1:2] : '0;
    w_mem_wdata = w_drive ? bus.i_data_wdata[int'(w_winner)*32 +: 32] : 32'b0;
    for (int p = 0; p < NUM_PE; p++) begin
      // Idle ports are granted so the upstream stage can always load.
      w_gnt[p] = i_rst_n & (~bus.i_data_req[p] | (w_any_req & (w_winner == PW'(p))));
    end
  end

  // Response pulse and read-data steering; i_mem_rdata never reaches grants.
  always_comb begin
    w_rvalid = '0;
    w_rdata  = '0;
    if (i_rst_n && r_rsp_v) begin
      w_rvalid[r_rsp_port] = 1'b1;
      if (!r_rsp_we) w_rdata[int'(r_rsp_port)*32 +: 32] = bus.i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_v    <= 1'b0;
      r_rsp_port <= '0;
      r_rsp_we   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      r_rsp_v <= w_any_req;
      if (w_any_req) begin
        r_rsp_port <= w_winner;
        r_rsp_we   <= bus.i_data_we[w_winner];
`ifndef MEM_ARB_FIXED_PRIO_EN
        r_rr_ptr   <= w_next_ptr;
`endif
      end
    end
  end

  assign bus.o_data_gnt    = w_gnt;
  assign bus.o_data_rvalid = w_rvalid;
  assign bus.o_data_rdata  = w_rdata;
  assign bus.o_mem_en      = w_drive;
  assign bus.o_mem_we      = w_mem_we;
  assign bus.o_mem_be      = w_mem_be;
  assign bus.o_mem_addr    = w_mem_addr;
  assign bus.o_mem_wdata   = w_mem_wdata;

endmodule

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Arbitrates the registered per-PE data requests produced by the one-cycle memory insertion stage onto a single-port SRAM bank, and returns grant, read-valid and read data to each PE. It sits directly downstream of the insertion stage and directly upstream of the bank.
- Its `o_data_gnt` is the only signal that lets the insertion stage advance, so idle ports must be granted.
- The round-robin pointer and response tag are its only state.

## Interface
- `NUM_PE`, default 3: number of requesting PEs.
- `MEM_AW`, default 14: bank word-address width.
- `i_clk` in, 1: clock.
- `i_rst_n` in, 1: reset, asynchronous, active-low.
- `i_data_addr` in, NUM_PE*32: byte addresses, port p at `[p*32+:32]`.
- `i_data_wdata` in, NUM_PE*32: write data.
- `i_data_we` in, NUM_PE: 1 = write, 0 = read.
- `i_data_req` in, NUM_PE: request valid.
- `i_data_be` in, NUM_PE*4: byte enables.
- `o_data_gnt` out, NUM_PE: accept / advance, per port.
- `o_data_rvalid` out, NUM_PE: response pulse, per port.
- `o_data_rdata` out, NUM_PE*32: read data, per port.
- `o_mem_en` out, 1: bank access enable.
- `o_mem_we` out, 1: bank write.
- `o_mem_be` out, 4: bank byte enables.
- `o_mem_addr` out, MEM_AW: word address, `= addr[MEM_AW+1:2]`; upper bits are ignored.
- `o_mem_wdata` out, 32: bank write data.
- `i_mem_rdata` in, 32: bank read data, valid one cycle after `o_mem_en` with `o_mem_we`=0.

## Operation
- **Winner selection:** each cycle, among requesting ports, the first one found searching upward from `rr_ptr` (modulo NUM_PE) wins.
- **Bank drive:** the winner's addr, wdata, we and be drive the bank combinationally, with `o_mem_en`=1. With no requests, `o_mem_en`=0 and the other bank outputs are 0.
- **Grant rule:** `o_data_gnt[p] = ~i_data_req[p] | (p == winner)`.
  - Non-requesting ports are always granted, so the upstream stage can load a new request.
  - Losing requesters see gnt=0 and must hold their request unchanged.
- **Pointer update:** on any grant to a requester, `rr_ptr <= (winner+1) mod NUM_PE`. With no requests, `rr_ptr` holds.
- **Response tag:** registered `rsp_v` and `rsp_port` capture whether a request was granted and which port won.
- **Response pulse:** next cycle, `o_data_rvalid[rsp_port]`=1 for exactly one cycle, for both reads and writes.
- **Read data:**
  - For reads, `o_data_rdata[rsp_port*32+:32] = i_mem_rdata`.
  - In every other case and for every other port, rdata = 0.
- **Reset state:** `rr_ptr`=0, `rsp_v`=0, `rsp_port`=0.
- **Outputs during reset:** `o_data_gnt`, `o_mem_en` and `o_data_rvalid` are forced to 0. All other outputs are 0 while `i_rst_n`=0.
- **Reset mid-operation:** a response pending in `rsp_v` is discarded and no rvalid is issued. After release, arbitration restarts from port 0.
- **Single requester:** it is granted every cycle, giving back-to-back throughput of one access per cycle.
- **Simultaneous requests:** with all NUM_PE requesting continuously, grants rotate p, p+1, … with no port starved for more than NUM_PE-1 cycles.

## Timing
- Request present in cycle N with the port winning: `o_data_gnt` is high in cycle N (combinational) and the bank access happens in N.
- Response: `o_data_rvalid` and `o_data_rdata` appear in cycle N+1.
- Latency from the arbiter input to the response is one cycle. From PE request to response it is two cycles, including the insertion stage.
- No combinational path exists from `i_mem_rdata` to `o_data_gnt`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - **Defined:** `rr_ptr` is removed and the lowest-indexed requesting port always wins. Port 0 may starve the others.
  - **Undefined (default):** round-robin as described above.

## Test plan
- **Reset:** hold `i_rst_n`=0 with all `i_data_req`=1 -> all of gnt, `o_mem_en` and rvalid are 0. After release, the first grant goes to port 0.
- **Single read:**
  - Stimulus: port 1 reads addr 0x0000_0010 and the bank returns 0xDEADBEEF.
  - Cycle N: gnt[1]=1, `o_mem_addr`=4, `o_mem_we`=0.
  - Cycle N+1: rvalid[1]=1 and `o_data_rdata[63:32]`=0xDEADBEEF; the other rdata fields are 0.
- **Write:** port 2 writes 0x12345678, be=4'b0011, addr 0x20 -> `o_mem_we`=1, `o_mem_be`=0011, `o_mem_addr`=8 and `o_mem_wdata` matches. Next cycle rvalid[2]=1 and rdata=0.
- **Round-robin:** all three ports request continuously for 6 cycles -> winners 0,1,2,0,1,2, and each loser's gnt=0 while its request is held. With `MEM_ARB_FIXED_PRIO_EN` defined, the winners are 0,0,0,0,0,0.
- **Idle grant:** ports 0 and 2 idle while port 1 requests -> gnt=3'b111 every cycle.
- **Reset mid-operation:** reset asserted in the cycle after a grant to port 0 -> no rvalid is issued. After release the pointer is 0, and port 1 and port 0 both requesting gives port 0 the win.
